// File: rtl/rs_syndrome.sv
// rs_syndrome: streaming Reed-Solomon syndrome calculator over GF(2^8), field polynomial 0x11D.
// It takes one received symbol per cycle, highest-degree symbol first. After N accepted
// symbols it presents all NSYM syndromes S_j = r(alpha^(j+FCR)) through a valid/ready output.
// Optional feature macro: SYN_ERRFLAG_EN adds the err_flag output, which is the OR of all syndromes.
module rs_syndrome #(
    parameter int m    = 255,
    parameter int SIZE = $clog2(m),
    parameter int N    = 255,
    parameter int NSYM = 16,
    parameter int FCR  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIZE-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NSYM*SIZE-1:0] out_syn
`ifdef SYN_ERRFLAG_EN
    ,
    output logic                 err_flag
`endif
);

    localparam logic [0:0]      ST_ACCUM = 1'b0;
    localparam logic [0:0]      ST_DONE  = 1'b1;
    localparam logic [SIZE-1:0] POLY_LOW = SIZE'(9'h11D);
    localparam logic [SIZE-1:0] CNT_LAST = SIZE'(N - 1);

    // Multiplies by alpha (x) once, reducing by the field polynomial.
    function automatic logic [SIZE-1:0] gfXtime(input logic [SIZE-1:0] a);
        return {a[SIZE-2:0], 1'b0} ^ (a[SIZE-1] ? POLY_LOW : '0);
    endfunction

    // Computes alpha^e. It is only evaluated on constants, so each call folds to a fixed byte.
    function automatic logic [SIZE-1:0] gfExp(input int e);
        logic [SIZE-1:0] a;
        a = SIZE'(1);
        for (int i = 0; i < e; i++) begin
            a = gfXtime(a);
        end
        return a;
    endfunction

    // Shift-and-add GF multiply. Because b is constant per lane, this reduces to an XOR network.
    function automatic logic [SIZE-1:0] gfMul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        logic [SIZE-1:0] p;
        logic [SIZE-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < SIZE; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = gfXtime(x);
        end
        return p;
    endfunction

    logic [0:0]           r_state;
    logic [SIZE-1:0]      r_cnt;
    logic [NSYM*SIZE-1:0] r_syn;
    logic [NSYM*SIZE-1:0] w_nextSyn;
    logic                 w_accept;
    logic                 w_lastAccept;
    logic                 w_outHandshake;

    assign in_ready       = (r_state == ST_ACCUM);
    assign out_valid      = (r_state == ST_DONE);
    assign out_syn        = r_syn;
    assign w_accept       = in_valid & in_ready;
    assign w_lastAccept   = w_accept & (r_cnt == CNT_LAST);
    assign w_outHandshake = out_valid & out_ready;

    // One Horner lane per syndrome. The first symbol of a block overwrites the lane,
    // so the previous block's result does not need a separate clear cycle.
    for (genvar j = 0; j < NSYM; j++) begin : gf_mul
        localparam logic [SIZE-1:0] ALPHA = gfExp((j + FCR) % m);
        assign w_nextSyn[j*SIZE +: SIZE] = (r_cnt == '0) ? in_data
                                         : (gfMul(r_syn[j*SIZE +: SIZE], ALPHA) ^ in_data);
    end

    // Sequences accumulation and output. The counter stays at N-1 until the output
    // handshake clears it, so it never wraps while the result is being held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
            r_cnt   <= '0;
            r_syn   <= '0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_syn <= w_nextSyn;
                        if (w_lastAccept) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_outHandshake) begin
                        r_state <= ST_ACCUM;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

`ifdef SYN_ERRFLAG_EN
    logic r_err;

    assign err_flag = r_err;

    // Registers the nonzero-syndrome summary together with the final syndromes.
    // The flag reads 0 whenever no result is being presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_lastAccept) begin
            r_err <= |w_nextSyn;
        end else if (w_outHandshake) begin
            r_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_rs_syndrome.sv
// tb_rs_syndrome: directed self-checking bench for rs_syndrome with default parameters
// (N=255, NSYM=16, FCR=0). Expected syndromes come from hand-computed constants and from a
// small log/exp-table GF model that builds a genuine RS codeword.
module tb_rs_syndrome;

    localparam int N    = 255;
    localparam int NSYM = 16;
    localparam logic [7:0] ALPHA_TAB [NSYM] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26
    };

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_data;
    logic               out_valid;
    logic               out_ready;
    logic [NSYM*8-1:0]  out_syn;
`ifdef SYN_ERRFLAG_EN
    logic               err_flag;
`endif

    int nChecks = 0;
    int nErrors = 0;

    logic [7:0]        blk [N];
    logic [NSYM*8-1:0] expOnes;
    logic [NSYM*8-1:0] expAlpha;
    logic [7:0]        expT [256];
    int                logT [256];

    rs_syndrome dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_syn   (out_syn)
`ifdef SYN_ERRFLAG_EN
        ,
        .err_flag  (err_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] modelMul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return expT[(logT[a] + logT[b]) % 255];
    endfunction

    task automatic buildTables();
        logic [7:0] a;
        a = 8'h01;
        for (int i = 0; i < 255; i++) begin
            expT[i] = a;
            logT[a] = i;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
        end
        expT[255] = 8'h01;
        logT[0]   = 0;
    endtask

    task automatic loadError(input int pos);
        for (int k = 0; k < N; k++) blk[k] = 8'h00;
        blk[N-1-pos] = 8'h01;
    endtask

    task automatic loadCodeword();
        logic [7:0] g [17];
        logic [7:0] msg [239];
        logic [7:0] c [N];
        for (int i = 0; i < 17; i++) g[i] = 8'h00;
        g[0] = 8'h01;
        for (int j = 0; j < NSYM; j++) begin
            for (int i = 16; i >= 1; i--) g[i] = g[i-1] ^ modelMul(g[i], expT[j]);
            g[0] = modelMul(g[0], expT[j]);
        end
        for (int i = 0; i < 239; i++) msg[i] = 8'(i * 7 + 3);
        for (int d = 0; d < N; d++) c[d] = 8'h00;
        for (int i = 0; i < 239; i++)
            for (int t = 0; t < 17; t++) c[i+t] = c[i+t] ^ modelMul(msg[i], g[t]);
        for (int k = 0; k < N; k++) blk[k] = c[N-1-k];
    endtask

    // Feeds blk[] and returns after the edge that consumes the last symbol (+1 time unit).
    task automatic feedBlock(input bit bubbles, output int cycles);
        int k;
        k = 0;
        cycles = 0;
        while (k < N && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (bubbles && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                in_data  = 8'hA5;
            end else begin
                in_valid = 1'b1;
                in_data  = blk[k];
                if (k == N-1) begin
                    nChecks++;
                    if (out_valid !== 1'b0) begin
                        nErrors++;
                        $display("[TB] FAIL early_valid: out_valid=%b before last accept, required 0", out_valid);
                    end
                end
                if (in_ready) k++;
            end
        end
        if (k < N) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL feed_timeout: accepted %0d symbols, required %0d", k, N);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic releaseOutput();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_syn !== '0) begin
            nErrors++;
            $display("[TB] FAIL reset_state: valid=%b ready=%b syn=%h, required 0 1 0", out_valid, in_ready, out_syn);
        end
`ifdef SYN_ERRFLAG_EN
        nChecks++;
        if (err_flag !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL reset_err: err_flag=%b, required 0", err_flag);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_all_zero();
        int cyc;
        for (int k = 0; k < N; k++) blk[k] = 8'h00;
        @(negedge clk);
        out_ready = 1'b1;
        feedBlock(1'b0, cyc);
        nChecks++;
        if (out_valid !== 1'b1 || out_syn !== '0) begin
            nErrors++;
            $display("[TB] FAIL zero_block: valid=%b syn=%h, required 1 and 0", out_valid, out_syn);
        end
`ifdef SYN_ERRFLAG_EN
        nChecks++;
        if (err_flag !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL zero_err: err_flag=%b, required 0", err_flag);
        end
`endif
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL zero_handshake: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_error_r0();
        int cyc;
        loadError(0);
        feedBlock(1'b0, cyc);
        nChecks++;
        if (out_valid !== 1'b1 || out_syn !== expOnes) begin
            nErrors++;
            $display("[TB] FAIL err_r0: valid=%b syn=%h, required 1 and %h", out_valid, out_syn, expOnes);
        end
`ifdef SYN_ERRFLAG_EN
        nChecks++;
        if (err_flag !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL err_r0_flag: err_flag=%b, required 1", err_flag);
        end
`endif
        releaseOutput();
    endtask

    task automatic test_error_r1();
        int cyc;
        loadError(1);
        feedBlock(1'b0, cyc);
        nChecks++;
        if (out_syn !== expAlpha) begin
            nErrors++;
            $display("[TB] FAIL err_r1: syn=%h, required %h", out_syn, expAlpha);
        end
        nChecks++;
        if (out_syn[8*8 +: 8] !== 8'h1D) begin
            nErrors++;
            $display("[TB] FAIL err_r1_s8: S8=%h, required 1d", out_syn[8*8 +: 8]);
        end
        releaseOutput();
    endtask

    task automatic test_backpressure();
        int cyc;
        loadError(0);
        feedBlock(1'b0, cyc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hFF ^ 8'(i);
            @(posedge clk);
            #1;
            nChecks++;
            if (out_syn !== expOnes || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                nErrors++;
                $display("[TB] FAIL hold_%0d: syn=%h ready=%b valid=%b, required %h 0 1", i, out_syn, in_ready, out_valid, expOnes);
            end
        end
        releaseOutput();
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nErrors++;
            $display("[TB] FAIL hold_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        loadError(1);
        feedBlock(1'b0, cyc);
        nChecks++;
        if (out_syn !== expAlpha) begin
            nErrors++;
            $display("[TB] FAIL after_hold: syn=%h, required %h", out_syn, expAlpha);
        end
        releaseOutput();
    endtask

    task automatic test_codeword_bubbles();
        int cyc;
        loadCodeword();
        feedBlock(1'b0, cyc);
        nChecks++;
        if (out_syn !== '0) begin
            nErrors++;
            $display("[TB] FAIL codeword_gapfree: syn=%h, required 0", out_syn);
        end
        releaseOutput();
        feedBlock(1'b1, cyc);
        nChecks++;
        if (out_valid !== 1'b1 || out_syn !== '0) begin
            nErrors++;
            $display("[TB] FAIL codeword_bubbles: valid=%b syn=%h, required 1 and 0", out_valid, out_syn);
        end
`ifdef SYN_ERRFLAG_EN
        nChecks++;
        if (err_flag !== 1'b0) begin
            nErrors++;
            $display("[TB] FAIL codeword_err: err_flag=%b, required 0", err_flag);
        end
`endif
        releaseOutput();
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        out_ready = 1'b1;
        loadError(0);
        feedBlock(1'b0, cyc);
        nChecks++;
        if (out_valid !== 1'b1 || out_syn !== expOnes) begin
            nErrors++;
            $display("[TB] FAIL b2b_first: valid=%b syn=%h, required 1 and %h", out_valid, out_syn, expOnes);
        end
        loadError(1);
        feedBlock(1'b0, cyc);
        nChecks++;
        if (cyc !== N + 1) begin
            nErrors++;
            $display("[TB] FAIL b2b_throughput: %0d cycles, required %0d", cyc, N + 1);
        end
        nChecks++;
        if (out_valid !== 1'b1 || out_syn !== expAlpha) begin
            nErrors++;
            $display("[TB] FAIL b2b_second: valid=%b syn=%h, required 1 and %h", out_valid, out_syn, expAlpha);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midblock();
        int cyc;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        nChecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_syn !== '0) begin
            nErrors++;
            $display("[TB] FAIL midreset_state: valid=%b ready=%b syn=%h, required 0 1 0", out_valid, in_ready, out_syn);
        end
        @(negedge clk);
        rst = 1'b0;
        loadError(0);
        feedBlock(1'b0, cyc);
        nChecks++;
        if (out_valid !== 1'b1 || out_syn !== expOnes) begin
            nErrors++;
            $display("[TB] FAIL midreset_result: valid=%b syn=%h, required 1 and %h", out_valid, out_syn, expOnes);
        end
        releaseOutput();
    endtask

    initial begin
        buildTables();
        for (int j = 0; j < NSYM; j++) begin
            expOnes[j*8 +: 8]  = 8'h01;
            expAlpha[j*8 +: 8] = ALPHA_TAB[j];
        end
        test_reset();
        test_all_zero();
        test_error_r0();
        test_error_r1();
        test_backpressure();
        test_codeword_bubbles();
        test_back_to_back();
        test_reset_midblock();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
